// File: rtl/layer_mem_pkg.sv
// Shared constants and types for the layer memory arbiter slice:
// bus widths, bank encodings, arbitration states and read owner tags.
package layer_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 13;

  // Bank select encodings as seen on e_sel/h_sel/m_sel
  localparam logic BANK_L0 = 1'b0;
  localparam logic BANK_L1 = 1'b1;

  // Arbitration priority states
  typedef enum logic {
    ENG_PRI  = 1'b0,
    HOST_PRI = 1'b1
  } arb_state_e;

  // Owner tag carried alongside an in-flight read
  localparam logic OWN_ENG  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  // Saturating 8-bit increment used by the host wait counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

endpackage

// File: rtl/layer_mem_arbiter_if.sv
// Bundle of the engine port, the host port and the memory macro port.
// slave  : the arbiter's view (takes requests, drives grants and the memory command).
// master : the surrounding system's view (requesters plus memory macro).
interface layer_mem_arbiter_if #(
  parameter int ADDR_W = layer_mem_pkg::ADDR_W,
  parameter int DATA_W = layer_mem_pkg::DATA_W
);
  import layer_mem_pkg::*;

  // Engine requester
  logic              e_req;
  logic              e_we;
  logic              e_sel;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  logic              e_gnt;
  logic              e_rvalid;
  logic [DATA_W-1:0] e_rdata;

  // Host requester
  logic              h_req;
  logic              h_we;
  logic              h_sel;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_gnt;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;

  // Memory macro
  logic              m_en;
  logic              m_we;
  logic              m_sel;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  e_req, e_we, e_sel, e_addr, e_wdata,
    output e_gnt, e_rvalid, e_rdata,
    input  h_req, h_we, h_sel, h_addr, h_wdata,
    output h_gnt, h_rvalid, h_rdata,
    output m_en, m_we, m_sel, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output e_req, e_we, e_sel, e_addr, e_wdata,
    input  e_gnt, e_rvalid, e_rdata,
    output h_req, h_we, h_sel, h_addr, h_wdata,
    input  h_gnt, h_rvalid, h_rdata,
    input  m_en, m_we, m_sel, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/layer_mem_rd_pipe.sv
// Two-stage read tracker: carries a valid bit and owner tag from grant to the
// cycle the memory returns data, then steers m_rdata to the owning requester.
// Each requester's rdata holds its last returned word between pulses.
module layer_mem_rd_pipe #(
  parameter int DATA_W = layer_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_i,    // a read was granted this cycle
  input  logic              owner_i,    // who owns that read
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              e_rvalid_o,
  output logic [DATA_W-1:0] e_rdata_o,
  output logic              h_rvalid_o,
  output logic [DATA_W-1:0] h_rdata_o
);
  import layer_mem_pkg::*;

  logic              vld1_q, own1_q;
  logic              vld2_q, own2_q;
  logic [DATA_W-1:0] e_hold_q, h_hold_q;

  // Advance the tag pipeline; reset drops anything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld1_q <= 1'b0;
      own1_q <= OWN_ENG;
      vld2_q <= 1'b0;
      own2_q <= OWN_ENG;
    end else begin
      vld1_q <= issue_i;
      own1_q <= owner_i;
      vld2_q <= vld1_q;
      own2_q <= own1_q;
    end
  end

  assign e_rvalid_o = vld2_q && (own2_q == OWN_ENG);
  assign h_rvalid_o = vld2_q && (own2_q == OWN_HOST);

  // Remember the last word returned to each requester
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_hold_q <= '0;
      h_hold_q <= '0;
    end else begin
      if (e_rvalid_o) e_hold_q <= m_rdata_i;
      if (h_rvalid_o) h_hold_q <= m_rdata_i;
    end
  end

  // Show live memory data during the pulse, the held word otherwise
  assign e_rdata_o = e_rvalid_o ? m_rdata_i : e_hold_q;
  assign h_rdata_o = h_rvalid_o ? m_rdata_i : h_hold_q;

endmodule

// File: rtl/layer_mem_arbiter.sv
// Arbiter sharing the single-port layer memory between the conv engine and
// the host port. Engine has default priority; a host wait counter forces one
// host access ahead of the engine after STARVE_LIMIT consecutive denials.
// Optional build macro ARB_STATS_EN adds per-requester stall counters.
module layer_mem_arbiter #(
  parameter int ADDR_W       = layer_mem_pkg::ADDR_W,
  parameter int DATA_W       = layer_mem_pkg::DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  layer_mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] e_stall_cnt,
  output logic [15:0] h_stall_cnt
`endif
);
  import layer_mem_pkg::*;

  localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);
  localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

  arb_state_e        state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              e_gnt, h_gnt;
  logic              host_denied;

  logic              m_en_q, m_we_q, m_sel_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;

  // State register and host wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ENG_PRI;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign host_denied = bus.h_req && !h_gnt;

  // Next state: escalate to host priority on the denial that hits the limit
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = host_denied ? sat_inc8(wait_cnt_q, LIMIT) : 8'd0;
    case (state_q)
      ENG_PRI: begin
        if (host_denied && (wait_cnt_q >= LIMIT_M1)) state_d = HOST_PRI;
      end
      HOST_PRI: begin
        if (h_gnt || !bus.h_req) begin
          state_d    = ENG_PRI;
          wait_cnt_d = 8'd0;
        end
      end
      default: state_d = ENG_PRI;
    endcase
  end

  // Grant outputs: combinational from requests and current priority
  always_comb begin
    e_gnt = 1'b0;
    h_gnt = 1'b0;
    case (state_q)
      HOST_PRI: begin
        h_gnt = bus.h_req;
        e_gnt = bus.e_req && !bus.h_req;
      end
      default: begin
        e_gnt = bus.e_req;
        h_gnt = bus.h_req && !bus.e_req;
      end
    endcase
  end

  assign bus.e_gnt = e_gnt;
  assign bus.h_gnt = h_gnt;

  // Register the winning request as the memory command; fields hold when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_sel_q   <= BANK_L0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      m_en_q <= e_gnt || h_gnt;
      if (h_gnt) begin
        m_we_q    <= bus.h_we;
        m_sel_q   <= bus.h_sel;
        m_addr_q  <= bus.h_addr;
        m_wdata_q <= bus.h_wdata;
      end else if (e_gnt) begin
        m_we_q    <= bus.e_we;
        m_sel_q   <= bus.e_sel;
        m_addr_q  <= bus.e_addr;
        m_wdata_q <= bus.e_wdata;
      end
    end
  end

  assign bus.m_en    = m_en_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_sel   = m_sel_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;

  logic rd_issue, rd_owner;
  assign rd_issue = (e_gnt && !bus.e_we) || (h_gnt && !bus.h_we);
  assign rd_owner = h_gnt ? OWN_HOST : OWN_ENG;

  layer_mem_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .issue_i   (rd_issue),
    .owner_i   (rd_owner),
    .m_rdata_i (bus.m_rdata),
    .e_rvalid_o(bus.e_rvalid),
    .e_rdata_o (bus.e_rdata),
    .h_rvalid_o(bus.h_rvalid),
    .h_rdata_o (bus.h_rdata)
  );

`ifdef ARB_STATS_EN
  logic [15:0] e_stall_q, h_stall_q;

  // Saturating counts of cycles each requester waited without a grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_stall_q <= 16'd0;
      h_stall_q <= 16'd0;
    end else begin
      if (bus.e_req && !e_gnt && (e_stall_q != 16'hFFFF)) e_stall_q <= e_stall_q + 16'd1;
      if (bus.h_req && !h_gnt && (h_stall_q != 16'hFFFF)) h_stall_q <= h_stall_q + 16'd1;
    end
  end

  assign e_stall_cnt = e_stall_q;
  assign h_stall_cnt = h_stall_q;
`endif

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Directed bench for layer_mem_arbiter with a behavioural single-port memory
// (registered read, one-cycle latency). Inputs change 1ns after each rising
// edge, outputs are examined 1ns later in the same cycle.
module tb_layer_mem_arbiter;
  import layer_mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  layer_mem_arbiter_if bus_if ();

`ifdef ARB_STATS_EN
  logic [15:0] e_stall_cnt, h_stall_cnt;
`endif

  layer_mem_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
`ifdef ARB_STATS_EN
    ,
    .e_stall_cnt(e_stall_cnt),
    .h_stall_cnt(h_stall_cnt)
`endif
  );

  // Behavioural memory macro: both banks, preloaded contents
  logic [12:0] mem0 [4096];
  logic [12:0] mem1 [4096];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem0[i] = 13'd0;
      mem1[i] = 13'd0;
    end
    for (int i = 0; i < 4; i++) mem0[i] = 13'(10 + i);
    mem1[7] = 13'h0AB;
    bus_if.m_rdata = 13'd0;
    forever begin
      @(posedge clk);
      if (bus_if.m_en) begin
        if (bus_if.m_we) begin
          if (bus_if.m_sel) mem1[bus_if.m_addr] = bus_if.m_wdata;
          else              mem0[bus_if.m_addr] = bus_if.m_wdata;
        end else begin
          bus_if.m_rdata <= bus_if.m_sel ? mem1[bus_if.m_addr] : mem0[bus_if.m_addr];
        end
      end
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of request fields, then settle
  task automatic drive(input logic er, input logic ew, input logic es,
                       input logic [11:0] ea, input logic [12:0] ed,
                       input logic hr, input logic hw, input logic hs,
                       input logic [11:0] ha, input logic [12:0] hd);
    @(posedge clk);
    #1;
    bus_if.e_req = er; bus_if.e_we = ew; bus_if.e_sel = es;
    bus_if.e_addr = ea; bus_if.e_wdata = ed;
    bus_if.h_req = hr; bus_if.h_we = hw; bus_if.h_sel = hs;
    bus_if.h_addr = ha; bus_if.h_wdata = hd;
    #1;
    if (er || hr)
      $display("t=%0t txn e_req=%0b e_we=%0b e_addr=%0h h_req=%0b h_we=%0b h_addr=%0h -> e_gnt=%0b h_gnt=%0b",
               $time, er, ew, ea, hr, hw, ha, bus_if.e_gnt, bus_if.h_gnt);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 12'd0, 13'd0, 1'b0, 1'b0, 1'b0, 12'd0, 13'd0);
  endtask

  initial begin
    logic hexp, hrv;
    bus_if.e_req = 0; bus_if.e_we = 0; bus_if.e_sel = 0; bus_if.e_addr = 0; bus_if.e_wdata = 0;
    bus_if.h_req = 0; bus_if.h_we = 0; bus_if.h_sel = 0; bus_if.h_addr = 0; bus_if.h_wdata = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    // Reset state
    chk("rst_m_en", 32'(bus_if.m_en), 32'd0);
    chk("rst_m_addr", 32'(bus_if.m_addr), 32'd0);
    chk("rst_e_gnt", 32'(bus_if.e_gnt), 32'd0);
    chk("rst_e_rvalid", 32'(bus_if.e_rvalid), 32'd0);
    chk("rst_e_rdata", 32'(bus_if.e_rdata), 32'd0);

    // Engine-only reads of bank 0 addr 0..3 -> 10..13 two cycles later
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b1, 1'b0, BANK_L0, 12'(i), 13'd0, 1'b0, 1'b0, 1'b0, 12'd0, 13'd0);
      else       idle();
      chk("t1_e_gnt", 32'(bus_if.e_gnt), 32'(i < 4));
      chk("t1_h_rvalid", 32'(bus_if.h_rvalid), 32'd0);
      chk("t1_e_rvalid", 32'(bus_if.e_rvalid), 32'(i >= 2 && i < 6));
      if (i >= 2) chk("t1_e_rdata", 32'(bus_if.e_rdata), (i < 6) ? 32'(10 + i - 2) : 32'd13);
    end

    // Both requesting continuously: host wins every 9th cycle
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, BANK_L0, 12'd0, 13'd0, 1'b1, 1'b0, BANK_L1, 12'd7, 13'd0);
      hexp = ((i % 9) == 8);
      chk("t2_e_gnt", 32'(bus_if.e_gnt), 32'(!hexp));
      chk("t2_h_gnt", 32'(bus_if.h_gnt), 32'(hexp));
      if (i >= 2) begin
        hrv = (((i - 2) % 9) == 8);
        chk("t2_h_rvalid", 32'(bus_if.h_rvalid), 32'(hrv));
        chk("t2_e_rvalid", 32'(bus_if.e_rvalid), 32'(!hrv));
        if (hrv) chk("t2_h_rdata", 32'(bus_if.h_rdata), 32'h0AB);
        else     chk("t2_e_rdata", 32'(bus_if.e_rdata), 32'd10);
      end
    end
    idle();
    idle();

    // Host write 0x1A5 to bank 1 addr 0x3FF, engine idle
    drive(1'b0, 1'b0, 1'b0, 12'd0, 13'd0, 1'b1, 1'b1, BANK_L1, 12'h3FF, 13'h1A5);
    chk("t3_h_gnt", 32'(bus_if.h_gnt), 32'd1);
    chk("t3_e_gnt", 32'(bus_if.e_gnt), 32'd0);
    idle();
    chk("t3_m_en", 32'(bus_if.m_en), 32'd1);
    chk("t3_m_we", 32'(bus_if.m_we), 32'd1);
    chk("t3_m_sel", 32'(bus_if.m_sel), 32'd1);
    chk("t3_m_addr", 32'(bus_if.m_addr), 32'h3FF);
    chk("t3_m_wdata", 32'(bus_if.m_wdata), 32'h1A5);
    idle();
    chk("t3_m_en_idle", 32'(bus_if.m_en), 32'd0);
    chk("t3_m_addr_hold", 32'(bus_if.m_addr), 32'h3FF);
    chk("t3_h_rvalid", 32'(bus_if.h_rvalid), 32'd0);
    chk("t3_e_rvalid", 32'(bus_if.e_rvalid), 32'd0);

    // Engine write 0x0F0 to addr 5, host reads addr 5 next cycle
    drive(1'b1, 1'b1, BANK_L0, 12'd5, 13'h0F0, 1'b0, 1'b0, 1'b0, 12'd0, 13'd0);
    chk("t4_e_gnt", 32'(bus_if.e_gnt), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 12'd0, 13'd0, 1'b1, 1'b0, BANK_L0, 12'd5, 13'd0);
    chk("t4_h_gnt", 32'(bus_if.h_gnt), 32'd1);
    chk("t4_e_rvalid_wr", 32'(bus_if.e_rvalid), 32'd0);
    idle();
    chk("t4_h_rvalid_early", 32'(bus_if.h_rvalid), 32'd0);
    idle();
    chk("t4_h_rvalid", 32'(bus_if.h_rvalid), 32'd1);
    chk("t4_h_rdata", 32'(bus_if.h_rdata), 32'h0F0);
    idle();
    chk("t4_h_rvalid_off", 32'(bus_if.h_rvalid), 32'd0);
    chk("t4_h_rdata_hold", 32'(bus_if.h_rdata), 32'h0F0);

    // Reset the cycle after a host read grant
    drive(1'b0, 1'b0, 1'b0, 12'd0, 13'd0, 1'b1, 1'b0, BANK_L1, 12'd7, 13'd0);
    chk("t5_h_gnt", 32'(bus_if.h_gnt), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus_if.h_req = 1'b0;
    #1;
    chk("t5_m_en", 32'(bus_if.m_en), 32'd0);
    chk("t5_m_sel", 32'(bus_if.m_sel), 32'd0);
    chk("t5_m_addr", 32'(bus_if.m_addr), 32'd0);
    chk("t5_h_rdata", 32'(bus_if.h_rdata), 32'd0);
    chk("t5_e_rdata", 32'(bus_if.e_rdata), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t5_h_rvalid_post", 32'(bus_if.h_rvalid), 32'd0);
      chk("t5_e_rvalid_post", 32'(bus_if.e_rvalid), 32'd0);
    end
    drive(1'b1, 1'b0, BANK_L0, 12'd0, 13'd0, 1'b1, 1'b0, BANK_L1, 12'd7, 13'd0);
    chk("t5_e_gnt_first", 32'(bus_if.e_gnt), 32'd1);
    chk("t5_h_gnt_first", 32'(bus_if.h_gnt), 32'd0);
    idle();

`ifdef ARB_STATS_EN
    // Host denied for 5 cycles after a fresh reset
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'b0, BANK_L0, 12'd0, 13'd0, 1'b1, 1'b0, BANK_L1, 12'd7, 13'd0);
    idle();
    chk("t6_h_stall", 32'(h_stall_cnt), 32'd5);
    chk("t6_e_stall", 32'(e_stall_cnt), 32'd0);
`endif

    repeat (3) idle();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
